// File: rtl/decode_queue.sv
// RV64 decode stage: combinational decode of in_inst feeding a DEPTH-entry FIFO of decoded records.
// One cycle from push to head; in_ready deasserts only when the FIFO is full; flush empties it.
module decode_queue #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 2,
  parameter bit ADDI_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_alu_ctrl,
  output logic            out_alu_src_imm,
  output logic            out_reg_write_enable,
  output logic            out_data_write_enable,
  output logic            out_reg_write_select,
  output logic [1:0]      out_branch,
  output logic            out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_OR  = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd2;
  localparam logic [1:0] ALU_SUB = 2'd3;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BLT  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [1:0]      alu_ctrl;
    logic            alu_src_imm;
    logic            reg_write_enable;
    logic            data_write_enable;
    logic            reg_write_select;
    logic [1:0]      branch;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};

  // Register indices are passed through raw even for illegal encodings.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    dec.illegal = 1'b1;
    case (opcode)
      7'b0000011: if (f3 == 3'b011) begin
        dec.illegal          = 1'b0;
        dec.reg_write_enable = 1'b1;
        dec.alu_ctrl         = ALU_ADD;
        dec.alu_src_imm      = 1'b1;
        dec.imm              = imm_i;
      end
      7'b0100011: if (f3 == 3'b011) begin
        dec.illegal           = 1'b0;
        dec.data_write_enable = 1'b1;
        dec.alu_ctrl          = ALU_ADD;
        dec.alu_src_imm       = 1'b1;
        dec.imm               = imm_s;
      end
      7'b0110011: begin
        if (f7 == 7'b0000000 && (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b000)) begin
          dec.illegal  = 1'b0;
          dec.alu_ctrl = (f3 == 3'b111) ? ALU_AND : (f3 == 3'b110) ? ALU_OR : ALU_ADD;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.illegal  = 1'b0;
          dec.alu_ctrl = ALU_SUB;
        end
        if (!dec.illegal) begin
          dec.reg_write_enable = 1'b1;
          dec.reg_write_select = 1'b1;
        end
      end
      7'b1100011: if (f3 == 3'b000 || f3 == 3'b100) begin
        dec.illegal  = 1'b0;
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = (f3 == 3'b000) ? BR_BEQ : BR_BLT;
        dec.imm      = imm_b;
      end
      7'b0010011: if (ADDI_EN && f3 == 3'b000) begin
        dec.illegal          = 1'b0;
        dec.reg_write_enable = 1'b1;
        dec.reg_write_select = 1'b1;
        dec.alu_ctrl         = ALU_ADD;
        dec.alu_src_imm      = 1'b1;
        dec.imm              = imm_i;
      end
      default: ;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head                  = mem[rd_ptr];
  assign out_pc                = head.pc;
  assign out_rs1               = head.rs1;
  assign out_rs2               = head.rs2;
  assign out_rd                = head.rd;
  assign out_imm               = head.imm;
  assign out_alu_ctrl          = head.alu_ctrl;
  assign out_alu_src_imm       = head.alu_src_imm;
  assign out_reg_write_enable  = head.reg_write_enable;
  assign out_data_write_enable = head.data_write_enable;
  assign out_reg_write_select  = head.reg_write_select;
  assign out_branch            = head.branch;
  assign out_illegal           = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (addi enabled / disabled) share one stimulus stream
// and are compared every cycle against a queue-of-instructions reference model.
module tb_decode_queue;
  localparam int DEPTH = 2;

  localparam logic [31:0] LD   = 32'h0081B503;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] SD   = 32'hFEA43C23;
  localparam logic [31:0] AND_ = 32'h00B57533;
  localparam logic [31:0] OR_  = 32'h00B56533;
  localparam logic [31:0] ADD_ = 32'h00B50533;
  localparam logic [31:0] SUB_ = 32'h40B50533;
  localparam logic [31:0] MUL  = 32'h02B50533;
  localparam logic [31:0] ADDI = 32'h00150513;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [1:0]  alu;
    logic        src, rwe, dwe, sel;
    logic [1:0]  br;
    logic        ill;
  } fields_t;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [63:0] pc_a, imm_a, pc_b, imm_b;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
  logic [1:0]  alu_a, br_a, alu_b, br_b;
  logic        src_a, rwe_a, dwe_a, sel_a, ill_a, src_b, rwe_b, dwe_b, sel_b, ill_b;
  fields_t     got_a, got_b;

  assign got_a = {pc_a, rs1_a, rs2_a, rd_a, imm_a, alu_a, src_a, rwe_a, dwe_a, sel_a, br_a, ill_a};
  assign got_b = {pc_b, rs1_b, rs2_b, rd_b, imm_b, alu_b, src_b, rwe_b, dwe_b, sel_b, br_b, ill_b};

  decode_queue #(.XLEN(64), .DEPTH(DEPTH), .ADDI_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(pc_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rd(rd_a), .out_imm(imm_a),
    .out_alu_ctrl(alu_a), .out_alu_src_imm(src_a), .out_reg_write_enable(rwe_a),
    .out_data_write_enable(dwe_a), .out_reg_write_select(sel_a), .out_branch(br_a),
    .out_illegal(ill_a));

  decode_queue #(.XLEN(64), .DEPTH(DEPTH), .ADDI_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(pc_b), .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b), .out_imm(imm_b),
    .out_alu_ctrl(alu_b), .out_alu_src_imm(src_b), .out_reg_write_enable(rwe_b),
    .out_data_write_enable(dwe_b), .out_reg_write_select(sel_b), .out_branch(br_b),
    .out_illegal(ill_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_f(input string name, input fields_t act, input fields_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef enum int {M_ILL, M_LD, M_SD, M_AND, M_OR, M_ADD, M_SUB, M_BEQ, M_BLT, M_ADDI} mn_t;

  // Instruction-level meaning of each mnemonic, straight from the ISA table.
  function automatic fields_t ref_decode(input logic [31:0] i, input logic [63:0] pc,
                                         input bit addi_en);
    fields_t f;
    mn_t m;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic signed [11:0] ii, si;
    logic signed [12:0] bi;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ii = i[31:20];
    si = {i[31:25], i[11:7]};
    bi = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    m = M_ILL;
    if      (op == 7'h03 && f3 == 3'd3) m = M_LD;
    else if (op == 7'h23 && f3 == 3'd3) m = M_SD;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) m = M_AND;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) m = M_OR;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) m = M_ADD;
    else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
    else if (op == 7'h63 && f3 == 3'd0) m = M_BEQ;
    else if (op == 7'h63 && f3 == 3'd4) m = M_BLT;
    else if (op == 7'h13 && f3 == 3'd0 && addi_en) m = M_ADDI;
    f = '0;
    f.pc = pc; f.rs1 = i[19:15]; f.rs2 = i[24:20]; f.rd = i[11:7];
    case (m)
      M_LD:   begin f.rwe = 1; f.alu = 2; f.src = 1; f.imm = 64'(ii); end
      M_SD:   begin f.dwe = 1; f.alu = 2; f.src = 1; f.imm = 64'(si); end
      M_AND:  begin f.rwe = 1; f.sel = 1; f.alu = 0; end
      M_OR:   begin f.rwe = 1; f.sel = 1; f.alu = 1; end
      M_ADD:  begin f.rwe = 1; f.sel = 1; f.alu = 2; end
      M_SUB:  begin f.rwe = 1; f.sel = 1; f.alu = 3; end
      M_BEQ:  begin f.alu = 3; f.br = 1; f.imm = 64'(bi); end
      M_BLT:  begin f.alu = 3; f.br = 2; f.imm = 64'(bi); end
      M_ADDI: begin f.rwe = 1; f.sel = 1; f.alu = 2; f.src = 1; f.imm = 64'(ii); end
      default: f.ill = 1;
    endcase
    return f;
  endfunction

  typedef struct { logic [31:0] inst; logic [63:0] pc; } ent_t;
  ent_t q[$];

  // Reference FIFO: accept when not full, release when non-empty, flush wins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      bit pu, po;
      pu = in_valid && (q.size() != DEPTH);
      po = out_ready && (q.size() != 0);
      if (flush) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back('{in_inst, in_pc});
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready_a", 64'(in_ready_a), 64'(q.size() != DEPTH));
    chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
    chk("in_ready_b", 64'(in_ready_b), 64'(q.size() != DEPTH));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk_f("head_a", got_a, ref_decode(q[0].inst, q[0].pc, 1'b1));
      chk_f("head_b", got_b, ref_decode(q[0].inst, q[0].pc, 1'b0));
    end
  end

  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] p,
                      input logic r, input logic f);
    @(negedge clk);
    in_valid = v; in_inst = i; in_pc = p; out_ready = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: begin r[6:0] = 7'h03; r[14:12] = 3'd3; end
      1: begin r[6:0] = 7'h23; r[14:12] = 3'd3; end
      2: begin r[6:0] = 7'h33; r[14:12] = 3'd7; r[31:25] = 7'h00; end
      3: begin r[6:0] = 7'h33; r[14:12] = 3'd6; r[31:25] = 7'h00; end
      4: begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h00; end
      5: begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'h20; end
      6: begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
      7: begin r[6:0] = 7'h63; r[14:12] = 3'd4; end
      8: begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
      9: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid_a), 64'd0);
    chk("rst in_ready", 64'(in_ready_a), 64'd1);
    chk_f("rst fields", got_a, '0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, LD, 64'h100, 1, 0);
    chk("ld valid", 64'(out_valid_a), 64'd1);
    chk("ld rs1", 64'(rs1_a), 64'd3);
    chk("ld rd", 64'(rd_a), 64'd10);
    chk("ld imm", imm_a, 64'd8);
    chk("ld rwe/sel/src", {61'd0, rwe_a, sel_a, src_a}, 64'b101);
    step(1, BEQ, 64'h104, 1, 0);
    chk("beq branch", 64'(br_a), 64'd1);
    chk("beq alu", 64'(alu_a), 64'd3);
    chk("beq imm", imm_a, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, SD, 64'h108, 1, 0);
    chk("sd dwe", 64'(dwe_a), 64'd1);
    chk("sd imm", imm_a, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 0, 0, 1, 0);

    step(1, AND_, 64'h200, 0, 0);
    chk("fill1 in_ready", 64'(in_ready_a), 64'd1);
    step(1, OR_, 64'h204, 0, 0);
    chk("full in_ready", 64'(in_ready_a), 64'd0);
    step(1, ADD_, 64'h208, 0, 0);
    chk("full head", pc_a, 64'h200);
    step(1, ADD_, 64'h20C, 1, 0);
    chk("full pushpop in_ready", 64'(in_ready_a), 64'd1);
    chk("full pushpop head", pc_a, 64'h204);
    step(1, SUB_, 64'h210, 1, 0);
    chk("cnt1 pushpop head", pc_a, 64'h210);
    chk("cnt1 pushpop in_ready", 64'(in_ready_a), 64'd1);
    chk("sub alu", 64'(alu_a), 64'd3);
    step(0, 0, 0, 1, 0);
    chk("drained", 64'(out_valid_a), 64'd0);

    step(1, 32'h0, 64'h300, 1, 0);
    chk("zero illegal", 64'(ill_a), 64'd1);
    chk("zero enables", {61'd0, rwe_a, dwe_a, src_a}, 64'd0);
    step(1, MUL, 64'h304, 1, 0);
    chk("mul illegal", 64'(ill_a), 64'd1);
    step(1, ADDI, 64'h308, 1, 0);
    chk("addi legal a", 64'(ill_a), 64'd0);
    chk("addi imm a", imm_a, 64'd1);
    chk("addi illegal b", 64'(ill_b), 64'd1);
    chk("addi rwe b", 64'(rwe_b), 64'd0);

    step(1, AND_, 64'h400, 0, 0);
    step(1, OR_, 64'h404, 0, 1);
    chk("flush out_valid", 64'(out_valid_a), 64'd0);
    chk("flush in_ready", 64'(in_ready_a), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        step(1, LD, 64'h500, 0, 0);
        step(1, SD, 64'h508, 0, 0);
        #2;
        chk("pre-rst out_valid", 64'(out_valid_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid_a), 64'd0);
        chk("async rst in_ready", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
           (n % 200 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0),
           $urandom_range(0, 60) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
